// File: rtl/frame_packer.sv
// frame_packer: packs a one-sample-per-clock stream into BUS_NUM-lane beats,
// frames them with tlast, and buffers whole frames in a FWFT FIFO. A frame is
// admitted only if a full frame of FIFO space is free when it starts; otherwise
// it is dropped whole and counted.
module frame_packer #(
    parameter int FFT_SIZE = 8192,
    parameter int BUS_NUM  = 2,
    parameter int FIFO_AW  = $clog2(FFT_SIZE / BUS_NUM) + 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      cnt_clr,
    input  logic                      s_valid,
    input  logic [31:0]               s_data,
    output logic                      out_tvalid,
    input  logic                      out_tready,
    output logic                      out_tlast,
    output logic [BUS_NUM-1:0][31:0]  out_tdata,
    output logic                      busy,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic [CNT_W-1:0]          frame_cnt
);
    // state | meaning
    // IDLE  | capture disabled, s_valid ignored
    // ARM   | waiting for the first sample of a frame; admit/drop decided there
    // FILL  | frame admitted, samples packed into beats and written to FIFO
    // DROP  | frame rejected, samples counted but discarded

    localparam int FRAME_BEATS = FFT_SIZE / BUS_NUM;
    localparam int DEPTH       = 1 << FIFO_AW;
    localparam int LW          = $clog2(BUS_NUM);
    localparam int BW          = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, ARM, FILL, DROP} state_t;

    state_t                   state, state_nx;
    logic [LW-1:0]            lane_cnt;
    logic [BW-1:0]            beat_cnt;
    logic                     last_lane, last_beat;
    logic                     smp_take, smp_keep, frame_end;
    logic [BUS_NUM-1:0][31:0] asm_q, beat_word, wr_data;
    logic                     wr_pend, wr_last;
    logic [32*BUS_NUM:0]      mem [DEPTH];
    logic [FIFO_AW:0]         wptr, rptr, mem_cnt, occ, free_cnt;
    logic                     rd_en;

    assign last_lane = (lane_cnt == LW'(BUS_NUM - 1));
    assign last_beat = (beat_cnt == BW'(FRAME_BEATS - 1));
    assign mem_cnt   = wptr - rptr;
    // The beat waiting to be written is already committed, so it counts as
    // occupied; this keeps the whole-frame reservation exact.
    assign occ       = mem_cnt + {{FIFO_AW{1'b0}}, out_tvalid} + {{FIFO_AW{1'b0}}, wr_pend};
    assign free_cnt  = (FIFO_AW + 1)'(DEPTH) - occ;
    assign rd_en     = (mem_cnt != '0) && (!out_tvalid || out_tready);
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and per-sample control
    always_comb begin
        state_nx  = state;
        smp_take  = 1'b0;
        smp_keep  = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: if (en) state_nx = ARM;
            ARM: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (s_valid) begin
                    smp_take = 1'b1;
                    if (free_cnt >= (FIFO_AW + 1)'(FRAME_BEATS)) begin
                        smp_keep = 1'b1;
                        state_nx = FILL;
                    end else begin
                        state_nx = DROP;
                    end
                end
            end
            FILL, DROP: begin
                if (s_valid) begin
                    smp_take = 1'b1;
                    smp_keep = (state == FILL);
                    if (last_lane && last_beat) begin
                        frame_end = 1'b1;
                        state_nx  = en ? ARM : IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Completed beat: stored lanes plus the sample arriving now in the top lane
    always_comb begin
        beat_word            = asm_q;
        beat_word[BUS_NUM-1] = s_data;
    end

    // Lane/beat counters, assembly register and the pending-write stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            beat_cnt <= '0;
            asm_q    <= '0;
            wr_pend  <= 1'b0;
            wr_last  <= 1'b0;
            wr_data  <= '0;
        end else begin
            wr_pend <= smp_keep && last_lane;
            if (smp_take) begin
                if (last_lane) begin
                    lane_cnt <= '0;
                    beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                end else begin
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end
            if (smp_keep) begin
                asm_q[lane_cnt] <= s_data;
                if (last_lane) begin
                    wr_data <= beat_word;
                    wr_last <= last_beat;
                end
            end
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (wr_pend) mem[wptr[FIFO_AW-1:0]] <= {wr_last, wr_data};
    end

    // FIFO pointers and the registered FWFT output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            out_tdata  <= '0;
        end else begin
            if (wr_pend) wptr <= wptr + 1'b1;
            if (rd_en) begin
                rptr                   <= rptr + 1'b1;
                out_tvalid             <= 1'b1;
                {out_tlast, out_tdata} <= mem[rptr[FIFO_AW-1:0]];
            end else if (out_tready) begin
                out_tvalid <= 1'b0;
            end
        end
    end

    // Sent/dropped frame counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else if (cnt_clr) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else if (frame_end) begin
            if (smp_keep)             frame_cnt <= frame_cnt + 1'b1;
            else if (~&drop_cnt)      drop_cnt  <= drop_cnt + 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_pend && (mem_cnt == (FIFO_AW + 1)'(DEPTH))));

endmodule

// File: tb/tb_frame_packer.sv
// Directed testbench for frame_packer with FFT_SIZE=16, BUS_NUM=2, FIFO_AW=4.
module tb_frame_packer;
    logic             clk = 1'b0;
    logic             rst_n, en, cnt_clr, s_valid, out_tready;
    logic [31:0]      s_data;
    logic             out_tvalid, out_tlast, busy;
    logic [1:0][31:0] out_tdata;
    logic [15:0]      drop_cnt, frame_cnt;

    int checks = 0;
    int failures = 0;
    logic [64:0] beats[$];

    frame_packer #(.FFT_SIZE(16), .BUS_NUM(2), .FIFO_AW(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cnt_clr(cnt_clr),
        .s_valid(s_valid), .s_data(s_data),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .out_tdata(out_tdata), .busy(busy), .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Record every beat that will be consumed at the next rising edge
    always @(negedge clk) begin
        if (rst_n && out_tvalid && out_tready) beats.push_back({out_tlast, out_tdata});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [64:0] exp_beat(input int base, input int b);
        logic [31:0] l0, l1;
        l0 = 32'(base + 2 * b);
        l1 = 32'(base + 2 * b + 1);
        return {(b == 7), l1, l0};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; cnt_clr = 1'b0; s_valid = 1'b0;
        s_data = '0; out_tready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        beats.delete();
    endtask

    task automatic drive_frame(input int base, input bit gapped);
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(base + i);
            step();
            if (gapped) begin
                s_valid = 1'b0;
                step();
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_tvalid !== 1'b0 || out_tlast !== 1'b0 || out_tdata !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h busy=%b expected all 0",
                     out_tvalid, out_tlast, out_tdata, busy);
        end
        checks++;
        if (drop_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: got drop=%0d frame=%0d expected 0 0", drop_cnt, frame_cnt);
        end
    endtask

    task automatic test_basic();
        do_reset();
        en = 1'b1; out_tready = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            step();
            if (i == 1 || i == 2) begin
                checks++;
                if (out_tvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_latency_early: sample %0d got tvalid=%b expected 0", i, out_tvalid);
                end
            end
            if (i == 3) begin
                checks++;
                if (out_tvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_latency: got tvalid=%b expected 1", out_tvalid);
                end
            end
        end
        s_valid = 1'b0;
        repeat (6) step();
        checks++;
        if (beats.size() != 8) begin
            failures++;
            $display("FAIL basic_count: got %0d beats expected 8", beats.size());
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (beats[j] !== exp_beat(0, j)) begin
                failures++;
                $display("FAIL basic_beat%0d: got %h expected %h", j, beats[j], exp_beat(0, j));
            end
        end
        checks++;
        if (frame_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL basic_frame_cnt: got frame=%0d drop=%0d expected 1 0", frame_cnt, drop_cnt);
        end
        en = 1'b0;
    endtask

    task automatic test_gapped();
        do_reset();
        en = 1'b1; out_tready = 1'b1;
        step();
        drive_frame(0, 1'b1);
        repeat (6) step();
        checks++;
        if (beats.size() != 8) begin
            failures++;
            $display("FAIL gapped_count: got %0d beats expected 8", beats.size());
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (beats[j] !== exp_beat(0, j)) begin
                failures++;
                $display("FAIL gapped_beat%0d: got %h expected %h", j, beats[j], exp_beat(0, j));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_backpressure();
        int nlast;
        do_reset();
        en = 1'b1; out_tready = 1'b0;
        step();
        drive_frame(0, 1'b0);
        drive_frame(16, 1'b0);
        drive_frame(32, 1'b0);
        en = 1'b0;
        repeat (3) step();
        checks++;
        if (frame_cnt !== 16'd2 || drop_cnt !== 16'd1) begin
            failures++;
            $display("FAIL bp_counters: got frame=%0d drop=%0d expected 2 1", frame_cnt, drop_cnt);
        end
        checks++;
        if (out_tvalid !== 1'b1 || beats.size() != 0) begin
            failures++;
            $display("FAIL bp_holding: got tvalid=%b beats=%0d expected 1 0", out_tvalid, beats.size());
        end
        out_tready = 1'b1;
        repeat (24) step();
        checks++;
        if (beats.size() != 16) begin
            failures++;
            $display("FAIL bp_count: got %0d beats expected 16", beats.size());
        end
        nlast = 0;
        for (int j = 0; j < 16; j++) begin
            if (beats[j][64]) nlast++;
            checks++;
            if (beats[j] !== exp_beat(16 * (j / 8), j % 8)) begin
                failures++;
                $display("FAIL bp_beat%0d: got %h expected %h", j, beats[j], exp_beat(16 * (j / 8), j % 8));
            end
        end
        checks++;
        if (nlast != 2) begin
            failures++;
            $display("FAIL bp_tlast_count: got %0d expected 2", nlast);
        end
    endtask

    task automatic test_en_drop();
        do_reset();
        en = 1'b1; out_tready = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            step();
            if (i == 5) en = 1'b0;
            if (i == 14 || i == 15) begin
                checks++;
                if (busy !== (i == 14)) begin
                    failures++;
                    $display("FAIL en_drop_busy: after sample %0d got busy=%b expected %b", i, busy, (i == 14));
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            s_data = 32'(100 + i);
            step();
        end
        s_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (beats.size() != 8 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL en_drop_count: got beats=%0d frame=%0d expected 8 1", beats.size(), frame_cnt);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (beats[j] !== exp_beat(0, j)) begin
                failures++;
                $display("FAIL en_drop_beat%0d: got %h expected %h", j, beats[j], exp_beat(0, j));
            end
        end
    endtask

    task automatic test_stability();
        logic [63:0]      pat;
        logic             stall, pl;
        logic [1:0][31:0] pd;
        pat = 64'hA5C3_0F96_3C5A_F00F;
        do_reset();
        en = 1'b1;
        step();
        for (int c = 0; c < 40; c++) begin
            out_tready = pat[c];
            s_valid    = (c < 16);
            s_data     = 32'(c);
            stall      = out_tvalid && !out_tready;
            pd         = out_tdata;
            pl         = out_tlast;
            step();
            if (stall) begin
                checks++;
                if (out_tvalid !== 1'b1 || out_tdata !== pd || out_tlast !== pl) begin
                    failures++;
                    $display("FAIL stall_hold: cycle %0d got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                             c, out_tvalid, out_tlast, out_tdata, pl, pd);
                end
            end
        end
        s_valid = 1'b0; out_tready = 1'b1;
        repeat (12) step();
        checks++;
        if (beats.size() != 8) begin
            failures++;
            $display("FAIL stall_count: got %0d beats expected 8", beats.size());
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (beats[j] !== exp_beat(0, j)) begin
                failures++;
                $display("FAIL stall_beat%0d: got %h expected %h", j, beats[j], exp_beat(0, j));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset_clear();
        do_reset();
        en = 1'b1; out_tready = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            step();
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_tvalid !== 1'b0 || out_tlast !== 1'b0 || out_tdata !== '0 || busy !== 1'b0 ||
            frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midframe_reset: got v=%b l=%b d=%h busy=%b frame=%0d expected all 0",
                     out_tvalid, out_tlast, out_tdata, busy, frame_cnt);
        end
        step();
        rst_n = 1'b1;
        beats.delete();
        repeat (6) step();
        checks++;
        if (beats.size() != 0 || out_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_quiet: got beats=%0d tvalid=%b expected 0 0", beats.size(), out_tvalid);
        end
        drive_frame(64, 1'b0);
        repeat (6) step();
        checks++;
        if (beats.size() != 8) begin
            failures++;
            $display("FAIL post_reset_count: got %0d beats expected 8", beats.size());
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (beats[j] !== exp_beat(64, j)) begin
                failures++;
                $display("FAIL post_reset_beat%0d: got %h expected %h", j, beats[j], exp_beat(64, j));
            end
        end

        do_reset();
        en = 1'b1; out_tready = 1'b0;
        step();
        drive_frame(0, 1'b0);
        drive_frame(16, 1'b0);
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(32 + i);
            cnt_clr = (i == 15);
            step();
        end
        s_valid = 1'b0; cnt_clr = 1'b0;
        checks++;
        if (drop_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL clr_priority: got drop=%0d frame=%0d expected 0 0", drop_cnt, frame_cnt);
        end
        drive_frame(48, 1'b0);
        checks++;
        if (drop_cnt !== 16'd1) begin
            failures++;
            $display("FAIL drop_after_clr: got drop=%0d expected 1", drop_cnt);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_en_drop();
        test_stability();
        test_reset_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_packer.md
Name: frame_packer

Overview:
- Upstream neighbour of the window-function stage.
- Takes a continuous one-sample-per-clock stream from the ADC/DDC front end (no backpressure available) and packs BUS_NUM consecutive samples into one AXI-Stream beat.
- Asserts tlast every FFT_SIZE/BUS_NUM beats and buffers frames in a FIFO so downstream stalls never split a frame.
- A frame that cannot be guaranteed a full FIFO slot is dropped whole and counted, so the window/FFT chain always sees complete, aligned packets.

Parameters:
- FFT_SIZE, 8192, samples per frame; must be a power of 2.
- BUS_NUM, 2, samples per output beat; power of 2, >= 2.
- FRAME_BEATS, FFT_SIZE/BUS_NUM, beats per frame (derived, not overridden).
- FIFO_AW, $clog2(FRAME_BEATS)+1, FIFO address width. Depth 2^FIFO_AW must be >= FRAME_BEATS.
- CNT_W, 16, width of the dropped-frame and sent-frame counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  capture enable (level)
- cnt_clr  in  1  synchronous clear of drop_cnt/frame_cnt
- s_valid  in  1  input sample valid; no ready, source cannot stall
- s_data  in  sample_t_int  input sample (re [15:0], im [31:16])
- out_tvalid  out  1  AXIS valid
- out_tready  in  1  AXIS ready
- out_tlast  out  1  last beat of frame
- out_tdata  out  sample_t_int [BUS_NUM]  packed beat; lane 0 = earliest sample
- busy  out  1  state != IDLE
- drop_cnt  out  CNT_W  frames dropped, saturating
- frame_cnt  out  CNT_W  frames fully written to FIFO, wrapping

Behaviour:
- Reset values: out_tvalid=0, out_tlast=0, out_tdata all 0, busy=0, drop_cnt=0, frame_cnt=0. FIFO empty, state IDLE, lane_cnt=0, beat_cnt=0.
- Counters: lane_cnt (0..BUS_NUM-1) and beat_cnt (0..FRAME_BEATS-1) advance only on s_valid in FILL/DROP. Both wrap to 0 at frame end.
- State machine:
  - IDLE: s_valid ignored.
  - IDLE -> ARM on en=1.
  - ARM: on the first s_valid, decide using the FIFO free count at that edge.
    - free >= FRAME_BEATS -> FILL; that sample goes to lane 0.
    - Otherwise -> DROP; that sample is discarded.
    - If en=0 while in ARM -> IDLE.
  - FILL: each sample goes to lane lane_cnt of the assembly register. The BUS_NUM-th sample commits the beat to the FIFO, with tlast = (beat_cnt==FRAME_BEATS-1).
  - DROP: samples are discarded, but the counters still advance.
  - At the last sample of a frame (lane_cnt==BUS_NUM-1 and beat_cnt==FRAME_BEATS-1):
    - FILL increments frame_cnt; DROP increments drop_cnt (saturates at all-ones).
    - Next state: ARM if en=1, else IDLE.
- en deasserted mid-frame (FILL or DROP): the current frame completes; no truncation and no partial frame.
- FIFO overflow is impossible by construction, since a full frame's space is reserved at frame start. An assertion must flag any write while full.
- Latency: the BUS_NUM-th sample of a beat is captured at edge k. The beat is written at edge k+1. If the FIFO was empty and out_tvalid=0, out_tvalid=1 after edge k+2.
- Output is a registered first-word-fall-through (FWFT) stage.
  - out_tvalid/out_tdata/out_tlast hold stable while out_tvalid & !out_tready.
  - A beat is consumed on out_tvalid & out_tready.
  - Back-to-back beats are supported with out_tready held 1 (one beat per clock from the FIFO).
- Free count = 2^FIFO_AW minus occupancy (including the output register). It is evaluated combinationally at the ARM decision edge. A read on the same edge does not count as freed space.
- cnt_clr has priority over a simultaneous increment: the result is 0.
- Asynchronous reset mid-frame returns all state to reset values, including discarding FIFO contents. No output beat is issued after reset until a new frame is captured.

Test Plan (FFT_SIZE=16, BUS_NUM=2, FIFO_AW=4 → FRAME_BEATS=8, depth 16):
- Basic frame: en=1, out_tready=1, 16 samples re=0..15, im=0, contiguous.
  - 8 beats with lane0/lane1 = {0,1},{2,3}…{14,15}.
  - out_tlast only on beat 7; frame_cnt=1.
  - First out_tvalid exactly 2 cycles after the capture of sample 1.
- Gapped input: s_valid toggling 1/0 over 16 samples.
  - Identical packing and tlast as the basic frame; no beat emitted on gaps.
- Backpressure: out_tready=0 throughout, 3 contiguous frames.
  - Frames 1-2 stored (frame_cnt=2); frame 3 dropped (drop_cnt=1).
  - Release ready → exactly 16 beats, 2 tlasts, data of frames 1-2 only.
- en drop mid-frame: en=0 after sample 5 of a frame.
  - Frame completes all 8 beats with tlast; busy falls after sample 15.
  - Further samples produce nothing.
- Output stability: ready toggled pseudo-randomly.
  - Output data/tlast never change while valid & !ready.
  - All beats delivered in order, none duplicated.
- Reset/clear: rst_n low after sample 7 → all outputs 0, no further beats.
  - After re-enable, the next frame starts at lane 0.
  - cnt_clr concurrent with a drop increment → drop_cnt=0.
